// File: rtl/rle_decoder_if.sv
// Handshake bundle for the run-length decoder: token input side and decoded
// word output side, plus the sticky overrun flag.
interface rle_decoder_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] din;
  logic             write;
  logic             full;
  logic [WIDTH-1:0] dout;
  logic             avail;
  logic             read;
  logic             err;

  modport master (
    output din, write, read,
    input  full, dout, avail, err
  );

  modport slave (
    input  din, write, read,
    output full, dout, avail, err
  );
endinterface

// File: rtl/rle_decoder.sv
// Run-length decoder: accepts (count, value) token pairs and emits count copies
// of value through a one-word output register with avail/read handshake.
module rle_decoder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  rle_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_VALUE = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] run_q, run_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             avail_q, avail_d;
  logic             err_q, err_d;

  logic full;
  logic accept;
  logic load;

  assign full   = rst | (state_q == S_EMIT);
  assign accept = bus.write & ~full;
  // The output register can take a new word when empty or being drained.
  assign load   = (state_q == S_EMIT) & (~avail_q | bus.read);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    val_d   = val_q;
    dout_d  = dout_q;
    avail_d = avail_q;
    err_d   = err_q;

    unique case (state_q)
      S_COUNT: begin
        if (accept) begin
          run_d   = bus.din;
          state_d = S_VALUE;
        end
      end
      S_VALUE: begin
        if (accept) begin
          val_d   = bus.din;
          state_d = (run_q == '0) ? S_COUNT : S_EMIT;
        end
      end
      S_EMIT: begin
        if (load) begin
          dout_d  = val_q;
          avail_d = 1'b1;
          run_d   = run_q - 1'b1;
          if (run_q == WIDTH'(1)) begin
            state_d = S_COUNT;
          end
        end
      end
      default: state_d = S_COUNT;
    endcase

    if (!load && avail_q && bus.read) begin
      avail_d = 1'b0;
    end

    if (bus.write && full) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_COUNT;
      run_q   <= '0;
      val_q   <= '0;
      dout_q  <= '0;
      avail_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      val_q   <= val_d;
      dout_q  <= dout_d;
      avail_q <= avail_d;
      err_q   <= err_d;
    end
  end

  assign bus.full  = full;
  assign bus.dout  = dout_q;
  assign bus.avail = avail_q;
  assign bus.err   = err_q;

endmodule
